// File: rtl/pc_fetch_unit.sv
// Program-counter unit for the fetch stage. It selects the next fetch address from the
// trap, stall, return, call, branch and sequential sources and keeps a circular return-address stack.
module pc_fetch_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            trap,
    input  logic            ret,
    input  logic            call,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    output logic            pc_valid,
    output logic            misaligned,
    output logic            ras_underflow,
    output logic            ras_empty,
    output logic            ras_full,
    output logic [31:0]     fetch_count
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RAS_DEPTH);

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_BOOT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t            state_reg;
    logic [XLEN-1:0]   pc_reg;
    logic              pc_valid_reg;
    logic              misaligned_reg;
    logic              underflow_reg;
    logic              empty_reg;
    logic              full_reg;
    logic [31:0]       fetch_count_reg;
    logic [PTR_W-1:0]  top_reg;
    logic [CNT_W-1:0]  cnt_reg;

    logic [XLEN-1:0]   ras_entries [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr_inc;
    logic [PTR_W-1:0]  ptr_dec;
    logic              push_en;

    // Next-state candidates for a RUN-state edge.
    logic [XLEN-1:0]   pc_next;
    logic [PTR_W-1:0]  top_next;
    logic [CNT_W-1:0]  cnt_next;
    logic              push_next;
    logic              load_next;
    logic              check_align;
    logic              misaligned_next;
    logic              underflow_next;

    assign PCPlus4       = pc_reg + XLEN'(4);
    assign PC            = pc_reg;
    assign pc_valid      = pc_valid_reg;
    assign misaligned    = misaligned_reg;
    assign ras_underflow = underflow_reg;
    assign ras_empty     = empty_reg;
    assign ras_full      = full_reg;
    assign fetch_count   = fetch_count_reg;

    assign ptr_inc = (top_reg == PTR_LAST) ? '0 : top_reg + PTR_W'(1);
    assign ptr_dec = (top_reg == '0) ? PTR_LAST : top_reg - PTR_W'(1);
    assign push_en = (state_reg == ST_RUN) && push_next;

    // top_reg points at the most recent entry; a push writes the slot after it,
    // which silently replaces the oldest entry once the stack is full.
    for (genvar gi = 0; gi < RAS_DEPTH; gi++) begin : g_ras
        logic [XLEN-1:0] entry_reg;
        always_ff @(posedge clk) begin
            if (push_en && (ptr_inc == PTR_W'(gi))) begin
                entry_reg <= PCPlus4;
            end
        end
        assign ras_entries[gi] = entry_reg;
    end

    always_comb begin
        pc_next         = PCPlus4;
        top_next        = top_reg;
        cnt_next        = cnt_reg;
        push_next       = 1'b0;
        load_next       = 1'b1;
        check_align     = 1'b0;
        misaligned_next = 1'b0;
        underflow_next  = 1'b0;
        if (trap) begin
            pc_next = TRAP_VECTOR;
        end else if (stall) begin
            pc_next   = pc_reg;
            load_next = 1'b0;
        end else if (ret) begin
            if (cnt_reg == '0) begin
                pc_next        = TRAP_VECTOR;
                underflow_next = 1'b1;
            end else begin
                pc_next     = ras_entries[top_reg];
                top_next    = ptr_dec;
                cnt_next    = cnt_reg - CNT_W'(1);
                check_align = 1'b1;
            end
        end else if (call) begin
            pc_next     = branch_target;
            push_next   = 1'b1;
            top_next    = ptr_inc;
            check_align = 1'b1;
            if (cnt_reg != CNT_MAX) begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end else if (branch_taken) begin
            pc_next     = branch_target;
            check_align = 1'b1;
        end
        // A misaligned redirect still lets a call's push go ahead.
        if (check_align && (pc_next[1:0] != 2'b00)) begin
            pc_next         = TRAP_VECTOR;
            misaligned_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_RST;
            pc_reg          <= RESET_VECTOR;
            pc_valid_reg    <= 1'b0;
            misaligned_reg  <= 1'b0;
            underflow_reg   <= 1'b0;
            empty_reg       <= 1'b1;
            full_reg        <= 1'b0;
            fetch_count_reg <= '0;
            top_reg         <= PTR_LAST;
            cnt_reg         <= '0;
        end else begin
            case (state_reg)
                ST_RST: begin
                    state_reg    <= ST_BOOT;
                    pc_reg       <= RESET_VECTOR;
                    pc_valid_reg <= 1'b1;
                end
                ST_BOOT: begin
                    state_reg <= ST_RUN;
                end
                ST_RUN: begin
                    pc_reg         <= pc_next;
                    top_reg        <= top_next;
                    cnt_reg        <= cnt_next;
                    misaligned_reg <= misaligned_next;
                    underflow_reg  <= underflow_next;
                    empty_reg      <= (cnt_next == '0);
                    full_reg       <= (cnt_next == CNT_MAX);
                    if (load_next) begin
                        fetch_count_reg <= fetch_count_reg + 32'd1;
                    end
                end
                default: begin
                    state_reg <= ST_RST;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed walk through the documented scenarios followed by
// random control traffic, all compared each cycle against a queue-based reference model.
module tb_pc_fetch_unit;

    localparam int          D  = 4;
    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset, stall, trap, ret, call, branch_taken;
    logic [31:0] branch_target;
    logic [31:0] PC, PCPlus4, fetch_count;
    logic        pc_valid, misaligned, ras_underflow, ras_empty, ras_full;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int          m_phase;
    logic [31:0] m_pc;
    logic        m_valid, m_mis, m_unf;
    logic [31:0] m_fc;
    logic [31:0] m_ras[$];

    always #5 clk = ~clk;

    pc_fetch_unit #(
        .XLEN(32), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .RAS_DEPTH(D)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .trap(trap), .ret(ret), .call(call),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .PC(PC), .PCPlus4(PCPlus4), .pc_valid(pc_valid), .misaligned(misaligned),
        .ras_underflow(ras_underflow), .ras_empty(ras_empty), .ras_full(ras_full),
        .fetch_count(fetch_count)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_redirect(input logic [31:0] addr);
        if (addr[1:0] != 2'b00) begin
            m_pc  = TV;
            m_mis = 1'b1;
        end else begin
            m_pc = addr;
        end
    endtask

    task automatic model_step(input logic r, s, t, rt, c, b, input logic [31:0] tgt);
        logic [31:0] link;
        if (r) begin
            m_phase = 0; m_pc = RV; m_valid = 0; m_mis = 0; m_unf = 0; m_fc = 0;
            m_ras.delete();
        end else if (m_phase == 0) begin
            m_phase = 1; m_valid = 1;
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else begin
            m_mis = 0; m_unf = 0;
            if (t) begin
                m_pc = TV; m_fc++;
            end else if (!s) begin
                m_fc++;
                if (rt) begin
                    if (m_ras.size() == 0) begin
                        m_pc = TV; m_unf = 1;
                    end else begin
                        model_redirect(m_ras.pop_back());
                    end
                end else if (c) begin
                    link = m_pc + 32'd4;
                    m_ras.push_back(link);
                    if (m_ras.size() > D) void'(m_ras.pop_front());
                    model_redirect(tgt);
                end else if (b) begin
                    model_redirect(tgt);
                end else begin
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic compare_all();
        check_value("PC", PC, m_pc);
        check_value("PCPlus4", PCPlus4, m_pc + 32'd4);
        check_value("pc_valid", 32'(pc_valid), 32'(m_valid));
        check_value("misaligned", 32'(misaligned), 32'(m_mis));
        check_value("ras_underflow", 32'(ras_underflow), 32'(m_unf));
        check_value("ras_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
        check_value("ras_full", 32'(ras_full), 32'(m_ras.size() == D));
        check_value("fetch_count", fetch_count, m_fc);
    endtask

    // Called at a falling edge: drive, let one rising edge pass, check at the next falling edge.
    task automatic cycle(input logic r, s, t, rt, c, b, input logic [31:0] tgt);
        reset = r; stall = s; trap = t; ret = rt; call = c; branch_taken = b; branch_target = tgt;
        model_step(r, s, t, rt, c, b, tgt);
        @(posedge clk);
        @(negedge clk);
        $display("txn r=%0b s=%0b t=%0b ret=%0b call=%0b br=%0b tgt=%h -> PC=%h fc=%0d",
                 r, s, t, rt, c, b, tgt, PC, fetch_count);
        compare_all();
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 32'h0);
    endtask

    task automatic do_call(input logic [31:0] tgt);
        cycle(0, 0, 0, 0, 1, 0, tgt);
    endtask

    task automatic do_ret();
        cycle(0, 0, 0, 1, 0, 0, 32'h0);
    endtask

    task automatic do_branch(input logic [31:0] tgt);
        cycle(0, 0, 0, 0, 0, 1, tgt);
    endtask

    initial begin
        logic r, s, t, rt, c, b;
        logic [31:0] tgt;
        m_phase = 0; m_pc = RV; m_valid = 0; m_mis = 0; m_unf = 0; m_fc = 0;
        @(negedge clk);

        // Reset, boot and sequential run.
        cycle(1, 0, 0, 0, 0, 0, 32'h0);
        cycle(1, 1, 1, 1, 1, 1, 32'h3);
        check_value("reset_valid", 32'(pc_valid), 32'd0);
        cycle(0, 0, 1, 0, 0, 1, 32'h40);
        check_value("boot_pc", PC, 32'h0);
        idle();
        check_value("run0_pc", PC, 32'h0);
        idle(); idle(); idle();
        check_value("seq_pc", PC, 32'hC);
        check_value("seq_fc", fetch_count, 32'd3);
        idle();

        // Stall then trap during stall.
        cycle(0, 1, 0, 0, 0, 0, 32'h0);
        cycle(0, 1, 0, 1, 1, 1, 32'h80);
        cycle(0, 1, 0, 0, 0, 0, 32'h0);
        check_value("stall_pc", PC, 32'h10);
        cycle(0, 1, 1, 0, 0, 0, 32'h0);
        check_value("trap_pc", PC, 32'h100);

        // Call and return.
        do_branch(32'h20);
        do_call(32'h200);
        idle();
        do_ret();
        check_value("ret_pc", PC, 32'h24);

        // Overfill the RAS, then drain it past empty.
        do_branch(32'h0);
        do_call(32'h40); do_call(32'h80); do_call(32'hC0); do_call(32'h100);
        check_value("full_after_4", 32'(ras_full), 32'd1);
        do_call(32'h300);
        do_ret(); check_value("ret1", PC, 32'h104);
        do_ret(); check_value("ret2", PC, 32'hC4);
        do_ret(); check_value("ret3", PC, 32'h84);
        do_ret(); check_value("ret4", PC, 32'h44);
        do_ret(); check_value("underflow", 32'(ras_underflow), 32'd1);

        // Misaligned branch, misaligned call still pushes, call+ret pops only.
        do_branch(32'h302);
        check_value("mis_pc", PC, 32'h100);
        idle();
        do_call(32'h201);
        do_call(32'h200);
        cycle(0, 0, 0, 1, 1, 0, 32'h400);
        check_value("callret_pc", PC, 32'h104);

        // Address wrap, then reset mid-run.
        do_branch(32'hFFFF_FFF8);
        idle(); idle();
        check_value("wrap_pc", PC, 32'h0);
        do_call(32'h500);
        cycle(1, 0, 1, 0, 1, 0, 32'h600);
        check_value("midreset_fc", fetch_count, 32'd0);
        idle(); idle();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            s  = ($urandom_range(0, 7) == 0);
            t  = ($urandom_range(0, 19) == 0);
            rt = ($urandom_range(0, 5) == 0);
            c  = ($urandom_range(0, 4) == 0);
            b  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) tgt = $urandom;
            else if ($urandom_range(0, 19) == 0) tgt = 32'hFFFF_FFF0 + ($urandom_range(0, 3) << 2);
            else tgt = $urandom_range(0, 1023) << 2;
            cycle(r, s, t, rt, c, b, tgt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
